// File: rtl/fp16_acc_ctrl.sv
// rtl/fp16_acc_ctrl.sv - FP16 accumulation controller driving an external combinational FP16 adder.
// Optional macro FP16ACC_EXC_EN: skip Inf/NaN elements and flag them on a sticky exc_o.
module fp16_acc_ctrl #(
  parameter int LEN_W = 8
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             start_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic             in_valid_i,
  input  logic [15:0]      in_data_i,
  output logic             in_ready_o,
  output logic [15:0]      add_a_o,
  output logic [15:0]      add_b_o,
  input  logic [15:0]      add_sum_i,
  output logic             res_valid_o,
  output logic [15:0]      res_data_o,
  input  logic             res_ready_i,
  output logic             busy_o,
  output logic             exc_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q;
  logic [15:0]      acc_q;
  logic [15:0]      acc_d;
  logic [LEN_W-1:0] cnt_q;
  logic [4:0]       in_exp;
  logic             in_inf_nan;

  assign in_exp     = in_data_i[14:10];
  assign in_inf_nan = (in_exp == 5'h1f);

  // The adder cannot take zero operands, so zeros are skipped and an empty
  // accumulator is loaded directly instead of going through the adder.
  always_comb begin
    acc_d = acc_q;
`ifdef FP16ACC_EXC_EN
    if (in_inf_nan) begin
      acc_d = acc_q;
    end else
`endif
    if (in_exp == 5'h00) begin
      acc_d = acc_q;
    end else if (acc_q[14:10] == 5'h00) begin
      acc_d = in_data_i;
    end else if (in_data_i == (acc_q ^ 16'h8000)) begin
      acc_d = 16'h0000;
    end else begin
      acc_d = add_sum_i;
    end
  end

`ifdef FP16ACC_EXC_EN
  logic exc_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      exc_q <= 1'b0;
    end else if (state_q == IDLE && start_i) begin
      exc_q <= 1'b0;
    end else if (state_q == ACC && in_valid_i && in_inf_nan) begin
      exc_q <= 1'b1;
    end
  end

  assign exc_o = exc_q;
`else
  logic unused_inf_nan;
  assign unused_inf_nan = in_inf_nan;
  assign exc_o = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      acc_q   <= 16'h0000;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            acc_q <= 16'h0000;
            if (len_i != '0) begin
              cnt_q   <= len_i;
              state_q <= ACC;
            end else begin
              state_q <= DONE;
            end
          end
        end
        ACC: begin
          if (in_valid_i) begin
            acc_q <= acc_d;
            cnt_q <= cnt_q - LEN_W'(1);
            if (cnt_q == LEN_W'(1)) begin
              state_q <= DONE;
            end
          end
        end
        DONE: begin
          if (res_ready_i) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready_o  = (state_q == ACC);
  assign res_valid_o = (state_q == DONE);
  assign busy_o      = (state_q != IDLE);
  assign res_data_o  = acc_q;
  assign add_a_o     = acc_q;
  assign add_b_o     = in_data_i;

endmodule

// File: tb/tb_fp16_acc_ctrl.sv
// tb/tb_fp16_acc_ctrl.sv - directed self-checking bench for fp16_acc_ctrl.
module tb_fp16_acc_ctrl;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  len = 8'd0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = 16'h0000;
  logic        in_ready;
  logic [15:0] add_a;
  logic [15:0] add_b;
  logic [15:0] add_sum;
  logic        res_valid;
  logic [15:0] res_data;
  logic        res_ready = 1'b0;
  logic        busy;
  logic        exc;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Stand-in for the external adder: only the sums these vectors need, Inf/NaN gives zero.
  function automatic logic [15:0] fp_add(input logic [15:0] a, input logic [15:0] b);
    case ({a, b})
      {16'h3C00, 16'h4000}, {16'h4000, 16'h3C00}: fp_add = 16'h4200;
      {16'h4200, 16'h3C00}, {16'h3C00, 16'h4200}: fp_add = 16'h4400;
      {16'h4000, 16'h4000}:                       fp_add = 16'h4400;
      {16'h3C00, 16'h3C00}:                       fp_add = 16'h4000;
      default:                                    fp_add = 16'h0000;
    endcase
  endfunction

  assign add_sum = fp_add(add_a, add_b);

  fp16_acc_ctrl #(.LEN_W(8)) dut (
    .clk_i       (clk),
    .rstn_i      (rstn),
    .start_i     (start),
    .len_i       (len),
    .in_valid_i  (in_valid),
    .in_data_i   (in_data),
    .in_ready_o  (in_ready),
    .add_a_o     (add_a),
    .add_b_o     (add_b),
    .add_sum_i   (add_sum),
    .res_valid_o (res_valid),
    .res_data_o  (res_data),
    .res_ready_i (res_ready),
    .busy_o      (busy),
    .exc_o       (exc)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic [7:0] n);
    start = 1'b1;
    len   = n;
    tick();
    start = 1'b0;
  endtask

  task automatic push(input logic [15:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic take_result();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (2) tick();
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
    n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_res_valid got %b exp 0", res_valid); end
    n_checks++; if (res_data !== 16'h0000) begin n_fail++; $display("FAIL reset_res_data got %h exp 0000", res_data); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
    n_checks++; if (exc !== 1'b0) begin n_fail++; $display("FAIL reset_exc got %b exp 0", exc); end
    n_checks++; if (add_a !== 16'h0000) begin n_fail++; $display("FAIL reset_add_a got %h exp 0000", add_a); end
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_basic_sum();
    start_run(8'd3);
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_in_ready got %b exp 1", in_ready); end
    in_data = 16'h1234;
    #1;
    n_checks++; if (add_b !== 16'h1234) begin n_fail++; $display("FAIL basic_add_b got %h exp 1234", add_b); end
    push(16'h3C00);
    push(16'h4000);
    n_checks++; if (add_a !== 16'h4200) begin n_fail++; $display("FAIL basic_partial got %h exp 4200", add_a); end
    n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid got %b exp 0", res_valid); end
    push(16'h3C00);
    n_checks++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid got %b exp 1", res_valid); end
    n_checks++; if (res_data !== 16'h4400) begin n_fail++; $display("FAIL basic_sum got %h exp 4400", res_data); end
    take_result();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_after got %b exp 0", busy); end
  endtask

  task automatic test_zero_and_cancel();
    start_run(8'd3);
    push(16'h3C00);
    push(16'h0000);
    push(16'h4000);
    n_checks++; if (res_data !== 16'h4200 || res_valid !== 1'b1) begin n_fail++; $display("FAIL zero_skip got %h/%b exp 4200/1", res_data, res_valid); end
    take_result();
    start_run(8'd3);
    push(16'h3C00);
    push(16'hBC00);
    n_checks++; if (add_a !== 16'h0000) begin n_fail++; $display("FAIL cancel_mid got %h exp 0000", add_a); end
    push(16'h4000);
    n_checks++; if (res_data !== 16'h4000 || res_valid !== 1'b1) begin n_fail++; $display("FAIL cancel_reload got %h/%b exp 4000/1", res_data, res_valid); end
    take_result();
  endtask

  task automatic test_backpressure();
    start_run(8'd0);
    n_checks++; if (res_valid !== 1'b1 || res_data !== 16'h0000) begin n_fail++; $display("FAIL empty_run got %b/%h exp 1/0000", res_valid, res_data); end
    take_result();
    start_run(8'd2);
    push(16'h4000);
    push(16'h4000);
    for (int i = 0; i < 5; i++) begin
      start = (i == 2);
      len   = 8'd1;
      tick();
      n_checks++;
      if (res_data !== 16'h4400 || res_valid !== 1'b1 || busy !== 1'b1 || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_%0d got data=%h valid=%b busy=%b ready=%b exp 4400/1/1/0", i, res_data, res_valid, busy, in_ready);
      end
    end
    start = 1'b0;
    take_result();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL hold_release_busy got %b exp 0", busy); end
    in_valid = 1'b1;
    in_data  = 16'h4000;
    tick();
    in_valid = 1'b0;
    n_checks++; if (in_ready !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL idle_valid got ready=%b busy=%b exp 0/0", in_ready, busy); end
  endtask

  task automatic test_stalls();
    start_run(8'd2);
    push(16'h4200);
    tick();
    tick();
    n_checks++; if (res_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL stall_wait got valid=%b ready=%b exp 0/1", res_valid, in_ready); end
    push(16'h3C00);
    n_checks++; if (res_data !== 16'h4400 || res_valid !== 1'b1) begin n_fail++; $display("FAIL stall_sum got %h/%b exp 4400/1", res_data, res_valid); end
    take_result();
  endtask

  task automatic test_reset_mid_run();
    start_run(8'd4);
    push(16'h3C00);
    push(16'h3C00);
    rstn = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0 || res_valid !== 1'b0 || res_data !== 16'h0000 || add_a !== 16'h0000 || exc !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst got busy=%b ready=%b valid=%b data=%h a=%h exc=%b exp all zero", busy, in_ready, res_valid, res_data, add_a, exc);
    end
    tick();
    rstn = 1'b1;
    tick();
    start_run(8'd1);
    push(16'h4000);
    n_checks++; if (res_data !== 16'h4000 || res_valid !== 1'b1) begin n_fail++; $display("FAIL after_rst got %h/%b exp 4000/1", res_data, res_valid); end
    take_result();
  endtask

  task automatic test_exception();
    logic        exp_exc;
    logic [15:0] exp_sum;
`ifdef FP16ACC_EXC_EN
    exp_exc = 1'b1;
    exp_sum = 16'h3C00;
`else
    exp_exc = 1'b0;
    exp_sum = 16'h0000;
`endif
    start_run(8'd2);
    push(16'h7C00);
    n_checks++; if (exc !== exp_exc) begin n_fail++; $display("FAIL exc_set got %b exp %b", exc, exp_exc); end
    push(16'h3C00);
    n_checks++; if (res_data !== exp_sum) begin n_fail++; $display("FAIL exc_sum got %h exp %h", res_data, exp_sum); end
    take_result();
    n_checks++; if (exc !== exp_exc) begin n_fail++; $display("FAIL exc_sticky got %b exp %b", exc, exp_exc); end
    start_run(8'd1);
    n_checks++; if (exc !== 1'b0 || add_a !== 16'h0000) begin n_fail++; $display("FAIL exc_clear got %b/%h exp 0/0000", exc, add_a); end
    push(16'h4000);
    take_result();
  endtask

  initial begin
    test_reset();
    test_basic_sum();
    test_zero_and_cancel();
    test_backpressure();
    test_stalls();
    test_reset_mid_run();
    test_exception();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fp16_acc_ctrl.md
# fp16_acc_ctrl

Sequential accumulation controller for the FP16 adder datapath. It accepts a stream of IEEE-754 half-precision values over a valid/ready handshake and drives the combinational FP16 adder with the running sum and the incoming element. It registers the adder result each cycle and returns the final sum over a second valid/ready handshake. The adder sits beside this block: it both feeds the adder's operand inputs and consumes its output.

## Interface
- LEN_W, 8, width of the element-count field
- clk_i  in  1  clock, rising edge
- rstn_i  in  1  reset, asynchronous, active-low
- start_i  in  1  begin a new accumulation; sampled only in IDLE
- len_i  in  LEN_W  number of elements to accumulate; sampled with start_i
- in_valid_i  in  1  input element valid
- in_data_i  in  16  input element {sign, exp[4:0], man[9:0]}
- in_ready_o  out  1  block can accept an element
- add_a_o  out  16  adder operand A, equal to the accumulator register
- add_b_o  out  16  adder operand B, equal to in_data_i (combinational)
- add_sum_i  in  16  adder result (combinational return)
- res_valid_o  out  1  final sum valid
- res_data_o  out  16  final sum
- res_ready_i  in  1  consumer accepts the sum
- busy_o  out  1  state is not IDLE
- exc_o  out  1  sticky: an Inf/NaN element was seen in the current run

## Operation
- State machine with three states: IDLE, ACC, DONE.
- IDLE:
  - start_i=1 and len_i≠0: go to ACC; cnt←len_i, acc←0x0000, exc←0.
  - start_i=1 and len_i=0: go to DONE; acc←0x0000, exc←0.
- ACC:
  - in_ready_o=1.
  - A handshake is in_valid_i & in_ready_o.
  - On each handshake, rules apply in priority order, with E = in_data_i[14:10]:
    1. E=31: acc unchanged. With the macro, set exc. Without the macro, see Configuration.
    2. E=0 (zero or subnormal): acc unchanged. The element is skipped, because the adder does not handle zero operands.
    3. acc[14:10]=0: acc←in_data_i (direct load, bypassing the adder).
    4. in_data_i == acc^16'h8000 (exact cancellation): acc←0x0000.
    5. Otherwise: acc←add_sum_i.
  - Every handshake decrements cnt, including skipped elements.
  - A handshake with cnt=1 moves the FSM to DONE.
- DONE:
  - res_valid_o=1, in_ready_o=0.
  - res_data_o=acc, held stable until res_ready_i=1.
  - On res_ready_i=1: go to IDLE.
- start_i outside IDLE is ignored.
- Outputs in_ready_o, res_valid_o, busy_o and exc_o are decoded from registered state and flags.
- add_b_o follows in_data_i in the same cycle. The path in_data_i → adder → acc is single-cycle.

## Timing
- Reset values:
  - State IDLE; acc=0x0000; cnt=0; exc=0.
  - in_ready_o=0, res_valid_o=0, res_data_o=0x0000, busy_o=0, exc_o=0.
  - add_a_o=0x0000.
- Throughput: one element per cycle in ACC.
- Latency: res_valid_o rises in the cycle after the last accepted element.
- When len_i=0: res_valid_o rises in the cycle after start_i.
- Result handshake: res_valid_o and res_ready_i both high in a cycle → IDLE in the next cycle, and busy_o falls.
- A new start_i is accepted from that IDLE cycle onward. There is no start/result overlap.
- Reset asserted mid-run: immediate return to reset values. The partial sum is discarded and no result is produced.
- in_valid_i asserted in IDLE or DONE: not accepted, and cnt is unchanged.

## Configuration
- Macro: FP16ACC_EXC_EN.
- Defined:
  - Elements with exp=31 are skipped (rule 1).
  - exc_o is set sticky and cleared on the next accepted start_i.
- Undefined:
  - exc_o is tied to 0.
  - Rule 1 is removed. Exp=31 elements fall through to the remaining rules. Since the adder returns 0x0000 for such operands, the accumulator becomes 0x0000, unless a direct load applies (rule 3).

## Test plan
- Basic sum: start len=3, inputs 0x3C00, 0x4000, 0x3C00 back-to-back → res_data_o=0x4400 (4.0), valid one cycle after the third accept.
- Zero skip and cancellation:
  - len=3, inputs 0x3C00, 0x0000, 0x4000 → 0x4200.
  - len=3, inputs 0x3C00, 0xBC00, 0x4000 → 0x4000 (cancel to zero, then direct load).
- Empty run and backpressure: start len=0 → res_valid_o=1 with 0x0000 next cycle. Then a len=2 run of 0x4000, 0x4000 with res_ready_i held low 5 cycles → res_data_o=0x4400 stable, busy_o=1, in_ready_o=0; start_i pulsed during DONE is ignored.
- Input stalls: len=2, in_valid_i toggled 1-0-0-1 with 0x4200, 0x3C00 → 0x4400; cnt decrements only on handshakes.
- Reset mid-run: after 2 of 4 elements, pulse rstn_i low → all outputs at reset values immediately; a following len=1 run with 0x4000 returns 0x4000.
- Exception (FP16ACC_EXC_EN defined): len=2, inputs 0x7C00, 0x3C00 → exc_o=1 from the cycle after the first accept, res_data_o=0x3C00; next start clears exc_o.
